seq_div_16bits: RTL and testbench

- Multi-cycle 16-bit restoring divider. It sits directly upstream of comp_adder_16bits and also consumes its result.
- Each iteration drives one trial subtraction through an internal comp_adder_16bits instance (sign=1, comp_e=1) and uses s/cout to decide the quotient bit.
- Gives the ALU a DIV path without a dedicated array divider. Uses a start/done handshake toward the ALU control FSM.

---
 rtl/seq_div_16bits.sv | 218 +++++++++++++++++++++
 tb/tb_seq_div_16bits.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16bits.sv
// Multi-cycle 16-bit restoring divider with a start/done handshake to the ALU control FSM.
// Define DIV_SIGNED_EN to add the is_signed input and a sign-fixup state after the iterations.

module comp_adder_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sign,
    input  logic        comp_e,
    output logic [15:0] s,
    output logic        cout,
    output logic        cout_1
);
    logic        sub;
    logic [15:0] b_eff;
    logic [16:0] full_sum;
    logic [15:0] low_sum;

    // Two's-complement subtract when both sign and comp_e are set; cout=1 means no borrow.
    always_comb begin
        sub      = sign & comp_e;
        b_eff    = sub ? ~b : b;
        full_sum = 17'(a) + 17'(b_eff) + 17'(sub);
        low_sum  = 16'(a[14:0]) + 16'(b_eff[14:0]) + 16'(sub);
        s        = full_sum[15:0];
        cout     = full_sum[16];
        cout_1   = low_sum[15];
    end
endmodule

module seq_div_16bits #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] SIGN = 2'd3;
`endif

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] rem_r, rem_n;
    logic [WIDTH-1:0] quo_r, quo_n;
    logic [WIDTH-1:0] div_r, div_n;
    logic             zero_r, zero_n;
    logic             busy_n, done_n, dbz_n;
    logic [WIDTH-1:0] quotient_n, remainder_n;

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] trial;
    logic             trial_cout;
    logic             unused_cout_1;
    logic             take;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_q_n;
    logic neg_r, neg_r_n;
    logic dvd_neg, dvs_neg;

    // Signed operands are reduced to magnitudes at acceptance; signs reapplied in SIGN.
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    // Partial remainder shifted left with the next dividend bit; rem_r msb is the 17th bit.
    assign r_sh = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    assign take = rem_r[WIDTH-1] | trial_cout;

    comp_adder_16bits u_adder (
        .a      (r_sh),
        .b      (div_r),
        .sign   (1'b1),
        .comp_e (1'b1),
        .s      (trial),
        .cout   (trial_cout),
        .cout_1 (unused_cout_1)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rem_n       = rem_r;
        quo_n       = quo_r;
        div_n       = div_r;
        zero_n      = zero_r;
        busy_n      = busy;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;
`ifdef DIV_SIGNED_EN
        neg_q_n     = neg_q;
        neg_r_n     = neg_r;
`endif
        case (state)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done) begin
                    busy_n = 1'b1;
                    cnt_n  = '0;
                    rem_n  = '0;
                    div_n  = dvs_mag;
                    if (divisor == '0) begin
                        quo_n   = dividend;
                        zero_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        quo_n   = dvd_mag;
                        zero_n  = 1'b0;
                        state_n = ITER;
                    end
`ifdef DIV_SIGNED_EN
                    neg_q_n = dvd_neg ^ dvs_neg;
                    neg_r_n = dvd_neg;
`endif
                end
            end
            ITER: begin
                quo_n = {quo_r[WIDTH-2:0], take};
                rem_n = take ? trial : r_sh;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == LAST_CNT) begin
`ifdef DIV_SIGNED_EN
                    state_n = SIGN;
`else
                    state_n = DONE;
                    busy_n  = 1'b0;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            SIGN: begin
                if (neg_q) quo_n = ~quo_r + WIDTH'(1);
                if (neg_r) rem_n = ~rem_r + WIDTH'(1);
                state_n = DONE;
                busy_n  = 1'b0;
            end
`endif
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
                if (zero_r) begin
                    quotient_n  = {WIDTH{1'b1}};
                    remainder_n = quo_r;
                    dbz_n       = 1'b1;
                end else begin
                    quotient_n  = quo_r;
                    remainder_n = rem_r;
                    dbz_n       = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            zero_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rem_r       <= rem_n;
            quo_r       <= quo_n;
            div_r       <= div_n;
            zero_r      <= zero_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
`ifdef DIV_SIGNED_EN
            neg_q       <= neg_q_n;
            neg_r       <= neg_r_n;
`endif
        end
    end
endmodule

// File: tb/tb_seq_div_16bits.sv
// Scoreboard bench for seq_div_16bits: randomized and directed divisions against an arithmetic model.
// Honours DIV_SIGNED_EN when it is defined for the build.

module tb_seq_div_16bits;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
    localparam int LAT          = 18;
`else
    localparam bit SIGNED_BUILD = 1'b0;
    localparam int LAT          = 17;
`endif

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic [31:0] done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          next_ok = 0;
    int          b_lo = 1;
    int          b_hi = 0;
    exp_t        exp_q[$];
    logic [15:0] held_q = '0;
    logic [15:0] held_r = '0;
    logic        held_z = 1'b0;

    seq_div_16bits dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sg);
        exp_t e;
        int   sa, sb, q, r;
        e = '0;
        if (b == 16'h0000) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sg) begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            e.q = 16'(q);
            e.r = 16'(r);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive one cycle of inputs; the model decides whether this start is accepted.
    task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b, input logic sg);
        int   c, lat, nb;
        exp_t e;
        @(negedge clk);
        start     = s;
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        c = cyc + 1;
        if (s && rst_n && c >= next_ok) begin
            e          = model(a, b, SIGNED_BUILD && is_signed);
            lat        = (b == 16'h0000) ? 1 : LAT;
            nb         = (b == 16'h0000) ? 1 : LAT - 1;
            e.done_cyc = 32'(c + lat);
            exp_q.push_back(e);
            b_lo    = c;
            b_hi    = c + nb - 1;
            next_ok = c + lat + 2;
        end
    endtask

    function automatic logic [15:0] rand_divisor();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return 16'h0000;
        if (sel < 3) return 16'($urandom_range(1, 15));
        return 16'($urandom);
    endfunction

    function automatic logic rand_sg();
        return SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (cyc + 1 >= next_ok) break;
            drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        end
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic sg);
        wait_ready();
        drive(1'b1, a, b, sg);
        wait_ready();
    endtask

    // Monitor: pops expectations on done, otherwise checks that outputs hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), e.done_cyc);
                    held_q = e.q;
                    held_r = e.r;
                    held_z = e.dbz;
                end
            end else if (exp_q.size() > 0 && cyc >= int'(exp_q[0].done_cyc)) begin
                e = exp_q.pop_front();
                chk("missing_done", 32'(done), 32'd1);
                held_q = e.q;
                held_r = e.r;
                held_z = e.dbz;
            end
            chk("quotient", 32'(quotient), 32'(held_q));
            chk("remainder", 32'(remainder), 32'(held_r));
            chk("div_by_zero", 32'(div_by_zero), 32'(held_z));
            chk("busy", 32'(busy), 32'(cyc >= b_lo && cyc <= b_hi));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        next_ok = cyc + 1;

        // Abort a division mid-iteration with reset.
        run_one(16'd50, 16'd3, 1'b0);
        wait_ready();
        drive(1'b1, 16'd100, 16'd7, 1'b0);
        repeat (4) drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        held_q = '0;
        held_r = '0;
        held_z = 1'b0;
        b_lo   = 1;
        b_hi   = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        next_ok = cyc + 1;

        // Directed cases, including the 17th-bit (carry_out_bit) path.
        run_one(16'd100, 16'd7, 1'b0);
        run_one(16'hFFFF, 16'h0001, 1'b0);
        run_one(16'h0005, 16'hFFFF, 1'b0);
        run_one(16'h8000, 16'h8000, 1'b0);
        run_one(16'hFFFF, 16'hFFFF, 1'b0);
        run_one(16'hFFFF, 16'h8001, 1'b0);
        run_one(16'hFFFE, 16'hFFFF, 1'b0);
        run_one(16'hC000, 16'hA000, 1'b0);
        run_one(16'h1234, 16'h0000, 1'b0);
        run_one(16'h0000, 16'h0000, 1'b0);
        run_one(16'h0000, 16'h0005, 1'b0);
`ifdef DIV_SIGNED_EN
        run_one(16'hFFF9, 16'h0002, 1'b1);
        run_one(16'h0007, 16'hFFFE, 1'b1);
        run_one(16'h8000, 16'hFFFF, 1'b1);
        run_one(16'h8000, 16'h0000, 1'b1);
        run_one(16'hFFF9, 16'hFFFE, 1'b1);
`endif

        // Start held high with operands changing every cycle.
        wait_ready();
        for (int i = 0; i < 90; i++)
            drive(1'b1, 16'($urandom), rand_divisor(), rand_sg());

        // Random starts, many landing while busy or on the done cycle.
        for (int i = 0; i < 900; i++)
            drive(1'($urandom_range(0, 2) == 0), 16'($urandom), rand_divisor(), rand_sg());

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        end
        repeat (3) drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
